// File: rtl/billiard_pkg.sv
// Shared types for the ball collision pair scheduler: FSM state encoding and
// the index-width helper used to size table indices.
package billiard_pkg;
  typedef enum logic [2:0] {IDLE, READ, CHECK, EMIT, DONE} sched_state_t;

  // Index width for a table of n balls; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ball_collision_detect.sv
// Combinational circle-overlap test: two balls of radius r collide when the
// squared centre distance is strictly below (2r)^2, evaluated in 2N bits.
module ball_collision_detect #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] xa,
  input  logic signed [N-1:0] ya,
  input  logic signed [N-1:0] xb,
  input  logic signed [N-1:0] yb,
  input  logic signed [N-1:0] r,
  output logic                collide
);
  logic signed [2*N-1:0] dx, dy, d;
  logic        [2*N-1:0] dist2, lim2;

  always_comb begin
    // Sign-extend before subtracting so the difference cannot wrap.
    dx    = {{N{xa[N-1]}}, xa} - {{N{xb[N-1]}}, xb};
    dy    = {{N{ya[N-1]}}, ya} - {{N{yb[N-1]}}, yb};
    d     = {{N{r[N-1]}}, r} <<< 1;
    dist2 = $unsigned(dx * dx) + $unsigned(dy * dy);
    lim2  = $unsigned(d * d);
    collide = dist2 < lim2;
  end
endmodule

// File: rtl/collision_pair_scheduler.sv
// Walks every unordered ball pair (i<j) of the position table, checks each
// pair with one shared detector and streams colliding pairs over valid/ready.
module collision_pair_scheduler import billiard_pkg::*; #(
  parameter int N         = 32,
  parameter int NUM_BALLS = 16,
  parameter int IDX_W     = idx_w(NUM_BALLS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic signed [N-1:0] radius,
  output logic [IDX_W-1:0]    rd_idx_a,
  output logic [IDX_W-1:0]    rd_idx_b,
  input  logic signed [N-1:0] rd_x_a,
  input  logic signed [N-1:0] rd_y_a,
  input  logic signed [N-1:0] rd_x_b,
  input  logic signed [N-1:0] rd_y_b,
  output logic                pair_valid,
  input  logic                pair_ready,
  output logic [IDX_W-1:0]    pair_i,
  output logic [IDX_W-1:0]    pair_j,
  output logic [2*IDX_W:0]    pair_count,
  output logic                busy,
  output logic                done
);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BALLS - 2);
  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BALLS - 1);

  sched_state_t        state;
  logic [IDX_W-1:0]    i, j, nxt_i, nxt_j;
  logic signed [N-1:0] r_lat;
  logic                collide, last, adv;

  ball_collision_detect #(.N(N)) u_det (
    .xa(rd_x_a), .ya(rd_y_a), .xb(rd_x_b), .yb(rd_y_b),
    .r(r_lat), .collide(collide)
  );

  always_comb begin
    last = (i == LAST_I) && (j == LAST_J);
    adv  = ((state == CHECK) && !collide) || ((state == EMIT) && pair_ready);
    if (j < LAST_J) begin
      nxt_i = i;
      nxt_j = j + IDX_W'(1);
    end else begin
      nxt_i = i + IDX_W'(1);
      nxt_j = i + IDX_W'(2);
    end
  end

  // Read indices are loaded on entry to READ so the synchronous table data
  // lines up with CHECK one cycle later.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      i          <= '0;
      j          <= IDX_W'(1);
      r_lat      <= '0;
      rd_idx_a   <= '0;
      rd_idx_b   <= '0;
      pair_i     <= '0;
      pair_j     <= '0;
      pair_valid <= 1'b0;
      pair_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      pair_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          r_lat      <= radius;
          pair_count <= '0;
          i          <= '0;
          j          <= IDX_W'(1);
          rd_idx_a   <= '0;
          rd_idx_b   <= IDX_W'(1);
          if (NUM_BALLS < 2) state <= DONE;
          else begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        READ:  state <= CHECK;
        CHECK: if (collide) begin
          pair_i     <= i;
          pair_j     <= j;
          pair_valid <= 1'b1;
          state      <= EMIT;
        end
        EMIT: if (pair_ready) begin
          pair_valid <= 1'b0;
          if (pair_count != '1) pair_count <= pair_count + 1'b1;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (adv) begin
        i        <= nxt_i;
        j        <= nxt_j;
        rd_idx_a <= nxt_i;
        rd_idx_b <= nxt_j;
        if (last) begin
          state <= DONE;
          busy  <= 1'b0;
        end else begin
          state <= READ;
        end
      end
    end
endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Self-checking bench: a pair-list model built from nested loops over the ball
// table is compared against the streamed pairs, plus directed corner cases.
module tb_collision_pair_scheduler;
  localparam int N  = 32;
  localparam int NB = 4;
  localparam int IW = 2;
  localparam int CW = 2*IW+1;

  logic clk = 1'b0;
  logic rst, start, abort, pair_ready, pair_valid, busy, done;
  logic signed [N-1:0] radius, rd_x_a, rd_y_a, rd_x_b, rd_y_b;
  logic [IW-1:0] rd_idx_a, rd_idx_b, pair_i, pair_j;
  logic [CW-1:0] pair_count;

  int xs[NB], ys[NB];
  int exp_q[$];
  int visits[$];
  int exp_cnt, exp_total, busy_cnt, rdy_mode;
  bit model_en;
  int n_cmp = 0, n_fail = 0;

  collision_pair_scheduler #(.N(N), .NUM_BALLS(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .radius(radius),
    .rd_idx_a(rd_idx_a), .rd_idx_b(rd_idx_b),
    .rd_x_a(rd_x_a), .rd_y_a(rd_y_a), .rd_x_b(rd_x_b), .rd_y_b(rd_y_b),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_i(pair_i), .pair_j(pair_j), .pair_count(pair_count),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // External ball table with one-cycle read latency.
  always @(posedge clk) begin
    rd_x_a <= xs[rd_idx_a];
    rd_y_a <= ys[rd_idx_a];
    rd_x_b <= xs[rd_idx_b];
    rd_y_b <= ys[rd_idx_b];
  end

  always @(posedge clk)
    if (rdy_mode == 1) begin
      #1;
      pair_ready = ($urandom_range(0, 3) != 0);
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Expected colliding pairs in scan order, straight from the geometry.
  function automatic void build(input int r);
    longint dx, dy;
    exp_q.delete();
    for (int a = 0; a < NB; a++)
      for (int b = a + 1; b < NB; b++) begin
        dx = longint'(xs[a]) - longint'(xs[b]);
        dy = longint'(ys[a]) - longint'(ys[b]);
        if (dx*dx + dy*dy < 4*longint'(r)*longint'(r)) exp_q.push_back(a*NB + b);
      end
  endfunction

  always @(negedge clk)
    if (model_en && !rst) begin
      if (busy) chk("pair_count_live", pair_count, exp_cnt);
      if (pair_valid) begin
        if (exp_q.size() == 0) chk("unexpected_pair", pair_i*NB + pair_j, -1);
        else begin
          chk("pair_ij", pair_i*NB + pair_j, exp_q[0]);
          if (pair_ready) begin
            void'(exp_q.pop_front());
            exp_cnt++;
          end
        end
      end
    end

  task automatic set_balls(input int x0, y0, x1, y1, x2, y2, x3, y3);
    xs[0] = x0; ys[0] = y0; xs[1] = x1; ys[1] = y1;
    xs[2] = x2; ys[2] = y2; xs[3] = x3; ys[3] = y3;
  endtask

  task automatic start_scan(input int r);
    build(r);
    exp_total = exp_q.size();
    exp_cnt   = 0;
    visits.delete();
    radius    = r;
    model_en  = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    radius = $urandom_range(0, 500);
  endtask

  task automatic wait_done(output int c);
    c = 0;
    busy_cnt = busy ? 1 : 0;
    visits.push_back(rd_idx_a*NB + rd_idx_b);
    while (!done && c < 3000) begin
      @(posedge clk); #1;
      c++;
      if (busy) busy_cnt++;
      if (c % 2 == 0 && c < 12) visits.push_back(rd_idx_a*NB + rd_idx_b);
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 3000 cycles");
    end
    chk("done_queue_empty", exp_q.size(), 0);
    chk("done_pair_count", pair_count, exp_total);
    model_en = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!pair_valid && k < 100) begin @(posedge clk); #1; k++; end
    chk("wait_valid", pair_valid, 1);
  endtask

  initial begin
    int c;
    rst = 1'b1; start = 1'b0; abort = 1'b0; pair_ready = 1'b1; radius = 0;
    rdy_mode = 0; model_en = 1'b0;
    set_balls(0, 0, 15, 0, 100, 100, 200, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_valid", pair_valid, 0);
    chk("rst_idx_b", rd_idx_b, 0); chk("rst_count", pair_count, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single colliding pair (0,1).
    build(10);
    chk("model1_size", exp_q.size(), 1);
    chk("model1_pair", exp_q[0], 1);
    start_scan(10); wait_done(c);
    chk("t1_count", pair_count, 1);

    // Distance exactly 2r: strict compare, no pair.
    set_balls(0, 0, 20, 0, 100, 100, 200, 0);
    build(10);
    chk("model2_size", exp_q.size(), 0);
    start_scan(10); wait_done(c);
    chk("t2_count", pair_count, 0);

    // No collisions: latency, busy length, visit order.
    set_balls(0, 0, 100, 0, 0, 100, 100, 100);
    start_scan(10); wait_done(c);
    chk("t3_latency", c, 13);
    chk("t3_busy_cycles", busy_cnt, 12);
    chk("t3_visit_n", visits.size(), 6);
    chk("t3_v0", visits[0], 1);  chk("t3_v1", visits[1], 2);
    chk("t3_v2", visits[2], 3);  chk("t3_v3", visits[3], 6);
    chk("t3_v4", visits[4], 7);  chk("t3_v5", visits[5], 11);

    // Backpressure: hold pair for 5 cycles.
    set_balls(0, 0, 15, 0, 100, 100, 200, 0);
    rdy_mode = 2; pair_ready = 1'b0;
    start_scan(10);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", pair_valid, 1);
      chk("t4_hold_ij", pair_i*NB + pair_j, 1);
    end
    pair_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_resume_valid", pair_valid, 0);
    chk("t4_resume_idx", rd_idx_a*NB + rd_idx_b, 2);
    chk("t4_resume_busy", busy, 1);
    wait_done(c);

    // Three mutually overlapping balls.
    set_balls(0, 0, 5, 0, 0, 5, 200, 0);
    build(10);
    chk("model6_size", exp_q.size(), 3);
    chk("model6_p0", exp_q[0], 1); chk("model6_p1", exp_q[1], 2); chk("model6_p2", exp_q[2], 6);
    rdy_mode = 0; pair_ready = 1'b1;
    start_scan(10); wait_done(c);
    chk("t6_count", pair_count, 3);

    // Abort during EMIT after one transfer: count kept, no done.
    pair_ready = 1'b0;
    start_scan(10);
    wait_valid();
    pair_ready = 1'b1;
    @(posedge clk); #1;
    pair_ready = 1'b0;
    wait_valid();
    model_en = 1'b0;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("t5_abort_valid", pair_valid, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_count", pair_count, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("t5_no_done", done, 0);
    end

    // start with abort in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("t5_start_abort_busy", busy, 0);

    // Reset mid-READ.
    pair_ready = 1'b1;
    radius = 10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5_pre_rst_busy", busy, 1);
    rst = 1'b1; #1;
    chk("t5_rst_busy", busy, 0); chk("t5_rst_idx_b", rd_idx_b, 0);
    chk("t5_rst_valid", pair_valid, 0); chk("t5_rst_done", done, 0);
    chk("t5_rst_count", pair_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized scans with random backpressure and mid-scan radius changes.
    rdy_mode = 1;
    for (int s = 0; s < 30; s++) begin
      for (int b = 0; b < NB; b++) begin
        xs[b] = $urandom_range(0, 80);
        ys[b] = $urandom_range(0, 80);
      end
      start_scan($urandom_range(1, 25));
      wait_done(c);
    end
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
